// File: rtl/rfaludm_ctrl_if.sv
// Sequencer <-> fetch/datapath bundle for rfaludm_ctrl.
// The slave modport is the controller; master is whoever drives start/instr/Zero.
interface rfaludm_ctrl_if;
   logic        start;
   logic [31:0] instr;
   logic        busy;
   logic        done;
   logic        illegal;
   logic        branch_taken;
   logic [18:0] branch_offset;
   logic        Zero;
   logic [5:0]  Read1;
   logic [5:0]  Read2;
   logic [5:0]  WriteReg;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        MemtoReg;
   logic [1:0]  ALUOp;
   logic [10:0] OpCodefield;
   logic [8:0]  SEin;
   logic [1:0]  AluSrc;

   modport master (
      output start, instr, Zero,
      input  busy, done, illegal, branch_taken, branch_offset,
             Read1, Read2, WriteReg, RegWrite, MemRead, MemWrite, MemtoReg,
             ALUOp, OpCodefield, SEin, AluSrc
   );

   modport slave (
      input  start, instr, Zero,
      output busy, done, illegal, branch_taken, branch_offset,
             Read1, Read2, WriteReg, RegWrite, MemRead, MemWrite, MemtoReg,
             ALUOp, OpCodefield, SEin, AluSrc
   );
endinterface

// File: rtl/rfaludm_ctrl.sv
// Multi-cycle LEGv8 sequencer for the RFALUDM datapath (DECODE/EXEC/MEM/WB/DONE).
// Define CTRL_CBZ_EN to decode CBZ; otherwise CBZ is reported as illegal.
module rfaludm_ctrl (
   input  logic          clock,
   input  logic          reset,
   rfaludm_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   logic [2:0]  state, nxt;
   logic [31:0] ir;
   logic [10:0] opc;
   logic        is_r, is_ld, is_st, is_cbz, is_ill, active;

   assign opc   = ir[31:21];
   assign is_r  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_ORR);
   assign is_ld = (opc == OP_LDUR);
   assign is_st = (opc == OP_STUR);
`ifdef CTRL_CBZ_EN
   assign is_cbz = (ir[31:24] == 8'b10110100);
`else
   assign is_cbz = 1'b0;
`endif
   assign is_ill = !(is_r || is_ld || is_st || is_cbz);
   assign active = (state != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         ir    <= 32'd0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && bus.start) ir <= bus.instr;
      end
   end

`ifdef CTRL_CBZ_EN
   // Zero is only meaningful while the CBZ operand sits on the ALU in EXEC.
   logic zq;
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                zq <= 1'b0;
      else if (state == S_EXEC) zq <= bus.Zero;
   end
   assign bus.branch_taken = (state == S_DONE) && is_cbz && zq;
`else
   assign bus.branch_taken = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (bus.start) nxt = S_DECODE;
         S_DECODE: nxt = is_ill ? S_DONE : S_EXEC;
         S_EXEC:   nxt = is_r ? S_WB : ((is_ld || is_st) ? S_MEM : S_DONE);
         S_MEM:    nxt = is_ld ? S_WB : S_DONE;
         S_WB:     nxt = S_DONE;
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.Read1         = 6'd0;
      bus.Read2         = 6'd0;
      bus.WriteReg      = 6'd0;
      bus.ALUOp         = 2'b00;
      bus.AluSrc        = 2'b00;
      bus.OpCodefield   = 11'd0;
      bus.SEin          = 9'd0;
      bus.branch_offset = 19'd0;
      if (active) begin
         bus.OpCodefield   = opc;
         bus.SEin          = ir[20:12];
         bus.branch_offset = ir[23:5];
         if (is_r) begin
            bus.Read1    = {1'b0, ir[9:5]};
            bus.Read2    = {1'b0, ir[20:16]};
            bus.WriteReg = {1'b0, ir[4:0]};
            bus.ALUOp    = 2'b10;
         end else if (is_ld || is_st) begin
            bus.Read1    = {1'b0, ir[9:5]};
            bus.Read2    = {1'b0, ir[4:0]};
            bus.WriteReg = {1'b0, ir[4:0]};
            bus.AluSrc   = 2'b01;
         end else if (is_cbz) begin
            bus.Read2    = {1'b0, ir[4:0]};
            bus.ALUOp    = 2'b01;
         end
      end
   end

   // Strobes decode straight from state, so an async reset drops them at once.
   assign bus.busy     = active;
   assign bus.done     = (state == S_DONE);
   assign bus.illegal  = (state == S_DONE) && is_ill;
   assign bus.MemRead  = (state == S_MEM) && is_ld;
   assign bus.MemWrite = (state == S_MEM) && is_st;
   assign bus.MemtoReg = ((state == S_MEM) || (state == S_WB)) && is_ld;
   assign bus.RegWrite = (state == S_WB) && (is_r || is_ld) && (ir[4:0] != 5'd31);
endmodule
